// File: rtl/gf180mcu_fd_sc_mcu9t5v0__deglitch_rx.sv
// Deglitching receiver: synchronizes I into CLK, qualifies each level change for FILT_CNT samples.
// Optional glitch counter (GCLR/GCNT ports) enabled by defining GF180MCU_DEGLITCH_RX_GCNT_EN.

module gf180mcu_fd_sc_mcu9t5v0__deglitch_rx_chk #(
    parameter int FILT_W   = 4,
    parameter int FILT_CNT = 8
) (
    input logic              clk,
    input logic              rst_n,
    input logic              zr,
    input logic              zf,
    input logic [FILT_W-1:0] cnt
);

    localparam logic [FILT_W-1:0] CNT_LIMIT = FILT_W'(FILT_CNT);

    a_pulse_excl: assert property (@(posedge clk) disable iff (!rst_n) !(zr && zf));
    a_cnt_bound:  assert property (@(posedge clk) disable iff (!rst_n) cnt < CNT_LIMIT);

endmodule

module gf180mcu_fd_sc_mcu9t5v0__deglitch_rx #(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_W      = 4,
    parameter int   FILT_CNT    = 8,
    parameter logic INIT        = 1'b0,
    parameter int   GCNT_W      = 8
) (
    input  logic              CLK,
    input  logic              RN,
    input  logic              I,
    input  logic              EN,
`ifdef GF180MCU_DEGLITCH_RX_GCNT_EN
    input  logic              GCLR,
`endif
    output logic              Z,
    output logic              ZR,
    output logic              ZF
`ifdef GF180MCU_DEGLITCH_RX_GCNT_EN
    ,
    output logic [GCNT_W-1:0] GCNT
`endif
);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_QUAL   = 1'b1
    } state_t;

    localparam logic [FILT_W-1:0] CNT_LAST = FILT_W'(FILT_CNT - 1);
    localparam logic [FILT_W-1:0] CNT_ONE  = FILT_W'(1);
    localparam logic [FILT_W-1:0] CNT_ZERO = FILT_W'(0);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   samp_s;
    state_t                 state_r;
    logic [FILT_W-1:0]      cnt_r;
    logic                   z_r;
    logic                   zr_r;
    logic                   zf_r;

    // Synchronizer chain; runs regardless of EN
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            sync_r <= {SYNC_STAGES{INIT}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], I};
        end
    end

    assign samp_s = sync_r[SYNC_STAGES-1];

    // Qualification FSM with registered level and edge pulses
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_r <= ST_STABLE;
            cnt_r   <= CNT_ZERO;
            z_r     <= INIT;
            zr_r    <= 1'b0;
            zf_r    <= 1'b0;
        end else begin
            zr_r <= 1'b0;
            zf_r <= 1'b0;
            if (!EN) begin
                state_r <= ST_STABLE;
                cnt_r   <= CNT_ZERO;
            end else begin
                case (state_r)
                    ST_STABLE: begin
                        if (samp_s != z_r) begin
                            // a single-sample filter commits without entering QUAL
                            if (FILT_CNT == 1) begin
                                z_r  <= samp_s;
                                zr_r <= samp_s;
                                zf_r <= ~samp_s;
                            end else begin
                                cnt_r   <= CNT_ONE;
                                state_r <= ST_QUAL;
                            end
                        end else begin
                            cnt_r <= CNT_ZERO;
                        end
                    end
                    ST_QUAL: begin
                        if (samp_s == z_r) begin
                            cnt_r   <= CNT_ZERO;
                            state_r <= ST_STABLE;
                        end else if (cnt_r == CNT_LAST) begin
                            z_r     <= samp_s;
                            zr_r    <= samp_s;
                            zf_r    <= ~samp_s;
                            cnt_r   <= CNT_ZERO;
                            state_r <= ST_STABLE;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                    default: begin
                        cnt_r   <= CNT_ZERO;
                        state_r <= ST_STABLE;
                    end
                endcase
            end
        end
    end

    assign Z  = z_r;
    assign ZR = zr_r;
    assign ZF = zf_r;

`ifdef GF180MCU_DEGLITCH_RX_GCNT_EN
    logic              reject_s;
    logic [GCNT_W-1:0] gcnt_r;

    // A glitch is a qualification abandoned because the sample fell back to Z
    always_comb begin
        reject_s = 1'b0;
        if (EN && (state_r == ST_QUAL) && (samp_s == z_r)) begin
            reject_s = 1'b1;
        end else begin
            reject_s = 1'b0;
        end
    end

    // Saturating glitch counter; clear wins over a same-cycle increment
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            gcnt_r <= {GCNT_W{1'b0}};
        end else if (GCLR) begin
            gcnt_r <= {GCNT_W{1'b0}};
        end else if (reject_s && (gcnt_r != {GCNT_W{1'b1}})) begin
            gcnt_r <= gcnt_r + GCNT_W'(1);
        end
    end

    assign GCNT = gcnt_r;
`endif

    gf180mcu_fd_sc_mcu9t5v0__deglitch_rx_chk #(
        .FILT_W   (FILT_W),
        .FILT_CNT (FILT_CNT)
    ) u_chk (
        .clk   (CLK),
        .rst_n (RN),
        .zr    (zr_r),
        .zf    (zf_r),
        .cnt   (cnt_r)
    );

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__deglitch_rx.sv
// Bench for the deglitching receiver: three instances (defaults, INIT=1, FILT_CNT=1)
// checked against a run-length reference model plus directed latency/boundary checks.

module tb_gf180mcu_fd_sc_mcu9t5v0__deglitch_rx;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic RN, I, EN, GCLR;
    logic dz [3];
    logic dzr[3];
    logic dzf[3];
`ifdef GF180MCU_DEGLITCH_RX_GCNT_EN
    logic [7:0] dg[3];
`endif

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [1:0] msh [3];
    logic       mz  [3];
    logic       mzr [3];
    logic       mzf [3];
    int         mrun[3];
    int         mg  [3];
    logic       ms;

    gf180mcu_fd_sc_mcu9t5v0__deglitch_rx #(.SYNC_STAGES(2), .FILT_W(4), .FILT_CNT(8), .INIT(1'b0), .GCNT_W(8)) u_dut0 (
        .CLK(CLK), .RN(RN), .I(I), .EN(EN),
`ifdef GF180MCU_DEGLITCH_RX_GCNT_EN
        .GCLR(GCLR),
`endif
        .Z(dz[0]), .ZR(dzr[0]), .ZF(dzf[0])
`ifdef GF180MCU_DEGLITCH_RX_GCNT_EN
        , .GCNT(dg[0])
`endif
    );

    gf180mcu_fd_sc_mcu9t5v0__deglitch_rx #(.SYNC_STAGES(2), .FILT_W(4), .FILT_CNT(8), .INIT(1'b1), .GCNT_W(8)) u_dut1 (
        .CLK(CLK), .RN(RN), .I(I), .EN(EN),
`ifdef GF180MCU_DEGLITCH_RX_GCNT_EN
        .GCLR(GCLR),
`endif
        .Z(dz[1]), .ZR(dzr[1]), .ZF(dzf[1])
`ifdef GF180MCU_DEGLITCH_RX_GCNT_EN
        , .GCNT(dg[1])
`endif
    );

    gf180mcu_fd_sc_mcu9t5v0__deglitch_rx #(.SYNC_STAGES(2), .FILT_W(4), .FILT_CNT(1), .INIT(1'b0), .GCNT_W(8)) u_dut2 (
        .CLK(CLK), .RN(RN), .I(I), .EN(EN),
`ifdef GF180MCU_DEGLITCH_RX_GCNT_EN
        .GCLR(GCLR),
`endif
        .Z(dz[2]), .ZR(dzr[2]), .ZF(dzf[2])
`ifdef GF180MCU_DEGLITCH_RX_GCNT_EN
        , .GCNT(dg[2])
`endif
    );

    function automatic int fc_of(input int k);
        return (k == 2) ? 1 : 8;
    endfunction

    function automatic logic init_of(input int k);
        return (k == 1) ? 1'b1 : 1'b0;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            msh[k]  = {2{init_of(k)}};
            mz[k]   = init_of(k);
            mzr[k]  = 1'b0;
            mzf[k]  = 1'b0;
            mrun[k] = 0;
            mg[k]   = 0;
        end
    endtask

    // Z follows the synchronized input once it has differed from Z for FILT_CNT enabled samples in a row
    task automatic model_edge();
        if (!RN) begin
            model_reset();
        end else begin
            for (int k = 0; k < 3; k++) begin
                ms     = msh[k][1];
                mzr[k] = 1'b0;
                mzf[k] = 1'b0;
                if (!EN) begin
                    mrun[k] = 0;
                end else if (ms != mz[k]) begin
                    mrun[k] = mrun[k] + 1;
                    if (mrun[k] == fc_of(k)) begin
                        mz[k]   = ms;
                        mzr[k]  = ms;
                        mzf[k]  = ~ms;
                        mrun[k] = 0;
                    end
                end else begin
                    if (mrun[k] > 0 && mg[k] < 255) mg[k] = mg[k] + 1;
                    mrun[k] = 0;
                end
                if (GCLR) mg[k] = 0;
                msh[k] = {msh[k][0], I};
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 3; k++) begin
            check_val($sformatf("z%0d", k),  32'(dz[k]),  32'(mz[k]));
            check_val($sformatf("zr%0d", k), 32'(dzr[k]), 32'(mzr[k]));
            check_val($sformatf("zf%0d", k), 32'(dzf[k]), 32'(mzf[k]));
`ifdef GF180MCU_DEGLITCH_RX_GCNT_EN
            check_val($sformatf("gcnt%0d", k), 32'(dg[k]), 32'(mg[k]));
`endif
        end
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #3;
        compare_all();
    endtask

    initial begin
        RN = 1'b0; I = 1'b0; EN = 1'b1; GCLR = 1'b0;
        model_reset();

        // reset held with I toggling
        for (int n = 0; n < 6; n++) begin
            step();
            I = ~I;
            check_val("rst_z_init0", 32'(dz[0]), 32'd1 - 32'd1);
            check_val("rst_z_init1", 32'(dz[1]), 32'd1);
            check_val("rst_pulses", 32'({dzr[0], dzf[0], dzr[1], dzf[1]}), 32'd0);
`ifdef GF180MCU_DEGLITCH_RX_GCNT_EN
            check_val("rst_gcnt", 32'(dg[0]), 32'd0);
`endif
        end
        I = 1'b0;
        step();
        RN = 1'b1;
        repeat (15) step();

        // clean rising edge
        I = 1'b1;
        for (int n = 1; n <= 11; n++) begin
            step();
            if (n == 2)  check_val("fc1_z_e2", 32'(dz[2]), 32'd0);
            if (n == 3)  check_val("fc1_z_e3", 32'(dz[2]), 32'd1);
            if (n == 9)  check_val("rise_z_e9", 32'(dz[0]), 32'd0);
            if (n == 10) check_val("rise_z_e10", 32'(dz[0]), 32'd1);
            if (n == 10) check_val("rise_zr_e10", 32'(dzr[0]), 32'd1);
            if (n == 11) check_val("rise_zr_e11", 32'(dzr[0]), 32'd0);
        end
        repeat (3) step();

        // clean falling edge
        I = 1'b0;
        for (int n = 1; n <= 11; n++) begin
            step();
            if (n == 9)  check_val("fall_zf_e9", 32'(dzf[0]), 32'd0);
            if (n == 10) check_val("fall_zf_e10", 32'(dzf[0]), 32'd1);
            if (n == 11) check_val("fall_zf_e11", 32'(dzf[0]), 32'd0);
        end
        repeat (3) step();

        // 5-cycle glitch is rejected and counted
        I = 1'b1;
        repeat (5) step();
        I = 1'b0;
        repeat (12) step();
        check_val("glitch_z", 32'(dz[0]), 32'd0);
`ifdef GF180MCU_DEGLITCH_RX_GCNT_EN
        check_val("glitch_gcnt", 32'(dg[0]), 32'd1);
`endif

        // clear held across another glitch
        GCLR = 1'b1;
        I = 1'b1;
        repeat (5) step();
        I = 1'b0;
        repeat (5) step();
        GCLR = 1'b0;
        repeat (5) step();
`ifdef GF180MCU_DEGLITCH_RX_GCNT_EN
        check_val("gclr_gcnt", 32'(dg[0]), 32'd0);
`endif

        // saturation
        for (int n = 0; n < 300; n++) begin
            I = 1'b1;
            repeat (5) step();
            I = 1'b0;
            repeat (6) step();
        end
`ifdef GF180MCU_DEGLITCH_RX_GCNT_EN
        check_val("sat_gcnt", 32'(dg[0]), 32'd255);
`endif
        GCLR = 1'b1;
        step();
        GCLR = 1'b0;
`ifdef GF180MCU_DEGLITCH_RX_GCNT_EN
        check_val("sat_clr", 32'(dg[0]), 32'd0);
`endif
        check_val("sat_z", 32'(dz[0]), 32'd0);

        // reset in the middle of a qualification
        I = 1'b1;
        repeat (5) step();
        RN = 1'b0;
        model_reset();
        #1;
        check_val("midq_rst_z", 32'(dz[0]), 32'd0);
        check_val("midq_rst_z1", 32'(dz[1]), 32'd1);
        step();
        step();
        RN = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            step();
            if (n == 9)  check_val("midq_z_e9", 32'(dz[0]), 32'd0);
            if (n == 10) check_val("midq_z_e10", 32'(dz[0]), 32'd1);
        end

        // EN=0 holds Z, FILT_CNT=1 follows one edge after enable
        I = 1'b0;
        repeat (12) step();
        EN = 1'b0;
        step();
        I = 1'b1;
        repeat (20) step();
        check_val("en0_z_fc1", 32'(dz[2]), 32'd0);
        check_val("en0_z_fc8", 32'(dz[0]), 32'd0);
        EN = 1'b1;
        step();
        check_val("en1_z_fc1", 32'(dz[2]), 32'd1);
        check_val("en1_zr_fc1", 32'(dzr[2]), 32'd1);
        repeat (12) step();

        // randomized segments
        for (int n = 0; n < 220; n++) begin
            I    = ~I;
            EN   = ($urandom_range(0, 9) != 0);
            GCLR = ($urandom_range(0, 19) == 0);
            repeat ($urandom_range(1, 14)) step();
        end
        EN = 1'b1;
        GCLR = 1'b0;
        repeat (12) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
